mld_7_3_decoder: RTL

//  Serial majority-logic decoder for the (7,3) cyclic code with g(x)=1+x^2+x^3+x^4,
//  the receive-side counterpart of the 4-stage systematic encoder.

---
 rtl/mld_pkg.sv | 33 +++
 rtl/mld_majority_3.sv | 30 +++
 rtl/mld_7_3_decoder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mld_pkg.sv
// -----------------------------------------------------------------------------
// mld_pkg
// Shared constants and types for the (7,3) cyclic-code majority-logic decoder
// with generator g(x) = 1 + x^2 + x^3 + x^4.
// Contents: code geometry (N, K), number of orthogonal check sums (J),
// default flip threshold, FSM state enum, and check-sum index table.
// -----------------------------------------------------------------------------
package mld_pkg;

  localparam int N          = 7;
  localparam int K          = 3;
  localparam int J          = 3;
  localparam int THRESH_DEF = 2;
  localparam int CNT_W      = 3;
  localparam int ERR_W      = 3;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DECODE  = 2'd1,
    HOLD    = 2'd2
  } state_e;

  typedef logic [2:0] idx_t;

  // Every check sum contains b6 (the bit under test) plus the two bits below.
  // The pairs are disjoint, so the three sums are orthogonal on b6.
  localparam idx_t CHK_IDX [J][2] = '{
    '{3'd3, 3'd4},
    '{3'd1, 3'd5},
    '{3'd0, 3'd2}
  };

endpackage

// File: rtl/mld_majority_3.sv
// -----------------------------------------------------------------------------
// mld_majority_3
// Combinational one-step majority gate: forms the three orthogonal check sums
// on the top bit of the word and asserts flip when at least THRESH of them fail.
// Ports:
//   word  in   N  current contents of the decode rotator, word[N-1] under test
//   flip  out  1  invert word[N-1] as it re-enters the rotator
// -----------------------------------------------------------------------------
module mld_majority_3
  import mld_pkg::*;
#(
  parameter int THRESH = THRESH_DEF
) (
  input  logic [N-1:0] word,
  output logic         flip
);

  logic [J-1:0] chk;
  logic [1:0]   fail_sum;

  always_comb begin
    chk = '0;
    for (int j = 0; j < J; j++) begin
      chk[j] = word[N-1] ^ word[CHK_IDX[j][0]] ^ word[CHK_IDX[j][1]];
    end
    fail_sum = 2'(chk[0]) + 2'(chk[1]) + 2'(chk[2]);
    flip     = (int'(fail_sum) >= THRESH);
  end

endmodule

// File: rtl/mld_7_3_decoder.sv
// -----------------------------------------------------------------------------
// mld_7_3_decoder
// Serial one-step majority-logic decoder for the (7,3) cyclic code,
// g(x) = 1 + x^2 + x^3 + x^4. Receives v6 first down to v0, then rotates the
// word seven times through the majority gate, correcting any single error.
// Ports:
//   clk           in   1  rising-edge clock
//   reset         in   1  asynchronous active-low reset
//   in_valid      in   1  in_bit valid this cycle
//   in_bit        in   1  received code bit
//   in_ready      out  1  decoder accepts a bit (COLLECT only)
//   out_valid     out  1  decoded word available
//   out_ready     in   1  consumer takes the word
//   out_data      out  3  corrected v[6:4]
//   out_codeword  out  7  corrected v[6:0]
//   out_err_cnt   out  3  number of bits flipped
//
// state   | meaning
// COLLECT | shift in received bits, seven accepted bits complete a word
// DECODE  | seven rotate-and-correct cycles, input stalled
// HOLD    | load output registers, then wait for out_ready
// -----------------------------------------------------------------------------
module mld_7_3_decoder
  import mld_pkg::*;
#(
  parameter int THRESH = THRESH_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic         in_bit,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] out_data,
  output logic [N-1:0] out_codeword,
  output logic [ERR_W-1:0] out_err_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_e             state_q, state_d;
  logic [N-1:0]       shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [K-1:0]       out_data_q, out_data_d;
  logic [N-1:0]       out_codeword_q, out_codeword_d;
  logic [ERR_W-1:0]   out_err_cnt_q, out_err_cnt_d;
  logic               flip;

  mld_majority_3 #(
    .THRESH (THRESH)
  ) u_majority (
    .word (shreg_q),
    .flip (flip)
  );

  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    cnt_d          = cnt_q;
    err_cnt_d      = err_cnt_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_codeword_d = out_codeword_q;
    out_err_cnt_d  = out_err_cnt_q;

    case (state_q)
      COLLECT: begin
        if (in_valid && in_ready_q) begin
          shreg_d = {shreg_q[N-2:0], in_bit};
          if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            err_cnt_d = '0;
            state_d   = DECODE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DECODE: begin
        // Rotating left brings each bit to the top once; after seven
        // rotations the word is back in its received alignment.
        shreg_d   = {shreg_q[N-2:0], shreg_q[N-1] ^ flip};
        err_cnt_d = err_cnt_q + ERR_W'(flip);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        // First HOLD cycle captures the result; afterwards wait for the
        // handshake. Output registers are left untouched on exit.
        if (!out_valid_q) begin
          out_valid_d    = 1'b1;
          out_codeword_d = shreg_q;
          out_data_d     = shreg_q[N-1:N-K];
          out_err_cnt_d  = err_cnt_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
        cnt_d   = '0;
      end
    endcase

    in_ready_d = (state_d == COLLECT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= COLLECT;
      shreg_q        <= '0;
      cnt_q          <= '0;
      err_cnt_q      <= '0;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_codeword_q <= '0;
      out_err_cnt_q  <= '0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      cnt_q          <= cnt_d;
      err_cnt_q      <= err_cnt_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_codeword_q <= out_codeword_d;
      out_err_cnt_q  <= out_err_cnt_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_codeword = out_codeword_q;
  assign out_err_cnt  = out_err_cnt_q;

endmodule
